// File: rtl/btn_conditioner_pkg.sv
// Shared game constants and the button-lane index encoding. Both this
// conditioner and the game core use them.
//   DEBOUNCE_MS_DEFAULT : default debounce stable time in milliseconds
//   BTN_COUNT           : number of push buttons on the controller
//   btn_idx_e           : press_code / button index -> note lane
package btn_conditioner_pkg;

  localparam int DEBOUNCE_MS_DEFAULT = 20;
  localparam int BTN_COUNT           = 4;

  typedef enum logic [1:0] {
    BTN_G3 = 2'd0,
    BTN_C4 = 2'd1,
    BTN_E4 = 2'd2,
    BTN_G5 = 2'd3
  } btn_idx_e;

endpackage

// File: rtl/btn_conditioner_milli_tick.sv
// Millisecond prescaler. It counts clock cycles and pulses ms_tick once
// every ticks_per_milli cycles. The game core shares this block.
//   clk             : system clock
//   rst             : asynchronous active-high reset
//   ticks_per_milli : clock cycles per millisecond (0 or 1 -> tick every cycle)
//   ms_tick         : one-cycle pulse at the end of each millisecond
module milli_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ticks_per_milli,
  output logic        ms_tick
);

  logic [15:0] cnt_q, cnt_d;

  // The >= test lets a mid-run reduction of ticks_per_milli wrap at once
  // instead of running on to the 16-bit rollover.
  always_comb begin
    if (ticks_per_milli <= 16'd1) begin
      ms_tick = 1'b1;
    end else begin
      ms_tick = (cnt_q >= (ticks_per_milli - 16'd1));
    end
    cnt_d = ms_tick ? '0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner. It synchronises the raw pins, debounces each
// button against a millisecond time base, and qualifies single presses.
//   clk, rst        : system clock, asynchronous active-high reset
//   ticks_per_milli : clock cycles per millisecond
//   btn_raw         : raw active-high pins, asynchronous to clk
//   btn_level       : debounced level per button
//   btn_press       : one-cycle pulse on each debounced 0->1 edge
//   press_valid     : one-cycle pulse for a lone press with no other button held
//   press_code      : index of the last qualified press (held)
//   chord           : more than one debounced button is high
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter  int NUM_BTN     = BTN_COUNT,
  parameter  int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
  localparam int CODE_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        ticks_per_milli,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               press_valid,
  output logic [CODE_W-1:0]  press_code,
  output logic               chord
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_MS);

  logic               ms_tick;
  logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic               valid_q, valid_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               chord_q, chord_d;

  milli_tick u_tick (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (ticks_per_milli),
    .ms_tick         (ms_tick)
  );

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Each button accumulates whole ms ticks while the synchronised input
  // disagrees with its debounced level. Any return to agreement discards the
  // accumulated time.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    logic [7:0] cnt_q, cnt_d;
    logic       lvl_d;

    always_comb begin
      cnt_d = cnt_q;
      lvl_d = level_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d = '0;
      end else if (ms_tick) begin
        if ((cnt_q + 8'd1) == DB_LIMIT) begin
          lvl_d = sync2_q[i];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    assign level_d[i] = lvl_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

  // Events are derived from the next level so that they register in the
  // same edge as the level change itself.
  always_comb begin
    press_d = level_d & ~level_q;
    valid_d = ($countones(press_d) == 1) && (level_d == press_d);
    code_d  = code_q;
    if (valid_d) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (press_d[i]) code_d = CODE_W'(i);
      end
    end
    chord_d = ($countones(level_d) > 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      chord_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      chord_q <= chord_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign press_valid = valid_q;
  assign press_code  = code_q;
  assign chord       = chord_q;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
  import btn_conditioner_pkg::*;

  localparam int NB = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] tpm = 16'd4;
  logic [3:0]  btn_raw = '0;
  logic [3:0]  btn_level, btn_press;
  logic        press_valid;
  logic [1:0]  press_code;
  logic        chord;

  int unsigned tests = 0;
  int unsigned fails = 0;

  btn_conditioner #(.NUM_BTN(NB), .DEBOUNCE_MS(DB)) dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (tpm),
    .btn_raw         (btn_raw),
    .btn_level       (btn_level),
    .btn_press       (btn_press),
    .press_valid     (press_valid),
    .press_code      (press_code),
    .chord           (chord)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset decide where ms boundaries fall; each
  // button remembers how many whole ms its synchronised input has disagreed
  // with its level.
  int unsigned m_k;
  logic [3:0]  m_s1, m_s2, m_level, m_press;
  logic        m_valid, m_chord;
  logic [1:0]  m_code;
  int unsigned m_ms [NB];
  bit          model_on = 1'b1;
  int unsigned press_events = 0;

  task automatic model_reset();
    m_k = 0; m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0;
    m_valid = 1'b0; m_chord = 1'b0; m_code = '0;
    for (int i = 0; i < NB; i++) m_ms[i] = 0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    bit         tick;
    logic [3:0] nl;
    tick = (tpm <= 16'd1) || ((m_k % tpm) == (tpm - 1));
    nl = m_level;
    for (int i = 0; i < NB; i++) begin
      if (m_s2[i] == m_level[i]) m_ms[i] = 0;
      else if (tick) begin
        m_ms[i]++;
        if (m_ms[i] == DB) begin
          nl[i] = m_s2[i];
          m_ms[i] = 0;
        end
      end
    end
    m_press = nl & ~m_level;
    m_valid = ($countones(m_press) == 1) && (nl == m_press);
    if (m_valid) for (int i = 0; i < NB; i++) if (m_press[i]) m_code = 2'(i);
    m_chord = ($countones(nl) > 1);
    m_level = nl;
    m_s2 = m_s1;
    m_s1 = raw;
    m_k++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (model_on) model_edge(btn_raw);
    #1;
    if (btn_press != 0) press_events++;
    if (model_on) begin
      check("level", btn_level, m_level);
      check("press", btn_press, m_press);
      check("valid", press_valid, m_valid);
      check("code", press_code, m_code);
      check("chord", chord, m_chord);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press, 0);
    check("rst_valid", press_valid, 0);
    check("rst_code", press_code, 0);
    check("rst_chord", chord, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_level(input logic [3:0] mask, input int unsigned bound,
                            output int unsigned n);
    n = 0;
    while (n < bound) begin
      step();
      n++;
      if ((btn_level & mask) != 0) break;
    end
  endtask

  int unsigned n;
  int          idx;

  initial begin
    model_reset();

    // Reset, then idle for 100 cycles.
    do_reset();
    press_events = 0;
    repeat (100) step();
    check("idle_no_press", press_events, 0);

    // Clean press of button 1 and release.
    btn_raw = 4'b0010;
    press_events = 0;
    wait_level(4'b0010, 30, n);
    check("clean_lat_window", (n >= 11 && n <= 15), 1);
    check("clean_press", btn_press, 4'b0010);
    check("clean_valid", press_valid, 1);
    check("clean_code", press_code, BTN_C4);
    step();
    check("clean_press_one_cycle", btn_press, 0);
    btn_raw = 4'b0000;
    repeat (20) step();
    check("release_level", btn_level, 0);
    check("release_no_event", press_events, 1);

    // Bounce: toggles every 5 cycles never accumulate three ms.
    press_events = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) btn_raw[0] = ~btn_raw[0];
      step();
    end
    check("bounce_no_press", press_events, 0);
    check("bounce_level", btn_level[0], 0);
    btn_raw = 4'b0001;
    repeat (25) step();
    check("bounce_one_press", press_events, 1);
    check("bounce_code", press_code, BTN_G3);
    btn_raw = 4'b0000;
    repeat (20) step();

    // Chord: press 0 while 3 is held, then two buttons together.
    btn_raw = 4'b1000;
    wait_level(4'b1000, 30, n);
    check("chord_g5_code", press_code, BTN_G5);
    btn_raw = 4'b1001;
    wait_level(4'b0001, 30, n);
    check("chord_press", btn_press, 4'b0001);
    check("chord_valid", press_valid, 0);
    check("chord_flag", chord, 1);
    check("chord_code_held", press_code, BTN_G5);
    btn_raw = 4'b0000;
    repeat (20) step();
    btn_raw = 4'b0110;
    wait_level(4'b0110, 30, n);
    check("dual_press", btn_press, 4'b0110);
    check("dual_valid", press_valid, 0);
    check("dual_chord", chord, 1);
    btn_raw = 4'b0000;
    repeat (20) step();

    // ticks_per_milli = 0: a tick every cycle.
    tpm = 16'd0;
    do_reset();
    btn_raw = 4'b0100;
    wait_level(4'b0100, 30, n);
    check("tpm0_lat_window", (n >= 5 && n <= 6), 1);
    check("tpm0_code", press_code, BTN_E4);
    btn_raw = 4'b0000;
    repeat (10) step();

    // Prescaler reduced mid-count wraps immediately.
    tpm = 16'd1000;
    do_reset();
    model_on = 1'b0;
    repeat (500) step();
    check("pre_tick_low", dut.u_tick.ms_tick, 0);
    tpm = 16'd4;
    #1;
    check("shrink_tick", dut.u_tick.ms_tick, 1);
    step();
    check("after_wrap_low", dut.u_tick.ms_tick, 0);
    repeat (3) step();
    check("next_period_tick", dut.u_tick.ms_tick, 1);
    model_on = 1'b1;

    // Reset mid-debounce restarts the full debounce.
    do_reset();
    btn_raw = 4'b0001;
    repeat (10) step();
    check("mid_not_yet", btn_level, 0);
    do_reset();
    press_events = 0;
    wait_level(4'b0001, 30, n);
    check("mid_lat_window", (n >= 11 && n <= 15), 1);
    check("mid_press", btn_press, 4'b0001);
    btn_raw = 4'b0000;
    repeat (10) step();

    // Randomized activity against the model.
    tpm = 16'($urandom_range(2, 6));
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, 3));
        btn_raw[idx] = ~btn_raw[idx];
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
